// File: rtl/rs_pkg.sv
// Shared Reed-Solomon decoder types: field width, default generator polynomial
// and the omega-evaluator state encoding.
package rs_pkg;

  localparam int GF_W = 8;
  localparam logic [GF_W:0] PRIM_POLY_DEF = 9'h11D;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } eval_state_e;

endpackage

// File: rtl/gf_mult8.sv
// Combinational GF(2^8) multiplier: shift-and-add product reduced mod PRIM_POLY.
// No state; result settles in the same cycle as the operands.
module gf_mult8 #(
  parameter logic [8:0] PRIM_POLY = 9'h11D
) (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] p_o
);

  localparam logic [7:0] RED = PRIM_POLY[7:0];

  logic [7:0] prod;
  logic [7:0] sh;

  // sh walks through a*x^i, folding the x^8 term back in with the low poly bits
  always_comb begin
    prod = '0;
    sh   = a_i;
    for (int i = 0; i < 8; i++) begin
      if (b_i[i]) prod = prod ^ sh;
      sh = sh[7] ? ({sh[6:0], 1'b0} ^ RED) : {sh[6:0], 1'b0};
    end
  end

  assign p_o = prod;

endmodule

// File: rtl/omega_evaluator.sv
// Horner evaluation of omega(x) from omega_buffer_1, highest coefficient first; done at D+3.
// Optional result_zero output under `OMEGA_EVAL_ZERO_FLAG_EN; start while busy is dropped.
module omega_evaluator
  import rs_pkg::*;
#(
  parameter logic [8:0] PRIM_POLY = PRIM_POLY_DEF,
  parameter int         DEG_W     = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       base_addr,
  input  logic [DEG_W-1:0] degree,
  input  logic [7:0]       eval_point,
  output logic [7:0]       rdaddress,
  output logic             rden,
  input  logic [7:0]       q,
  output logic             busy,
  output logic             done,
  output logic [7:0]       result
`ifdef OMEGA_EVAL_ZERO_FLAG_EN
  ,
  output logic             result_zero
`endif
);

  eval_state_e      state_q;
  logic [7:0]       base_q;
  logic [7:0]       x_q;
  logic [DEG_W-1:0] k_q;
  logic [7:0]       acc_q;
  logic [7:0]       acc_d;
  logic             q_vld_q;
  logic             rden_q;
  logic [7:0]       rdaddress_q;
  logic             busy_q;
  logic             done_q;
  logic [7:0]       result_q;
  logic [7:0]       mul_p;

  gf_mult8 #(.PRIM_POLY(PRIM_POLY)) u_mul (
    .a_i (acc_q),
    .b_i (x_q),
    .p_o (mul_p)
  );

  // q is only meaningful the cycle after a read was issued
  always_comb begin
    acc_d = acc_q;
    if (q_vld_q) acc_d = mul_p ^ q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      base_q      <= '0;
      x_q         <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      q_vld_q     <= 1'b0;
      rden_q      <= 1'b0;
      rdaddress_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
    end else begin
      q_vld_q <= rden_q;
      acc_q   <= acc_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            base_q      <= base_addr;
            x_q         <= eval_point;
            k_q         <= degree;
            acc_q       <= '0;
            rden_q      <= 1'b1;
            rdaddress_q <= base_addr + 8'(degree);
            busy_q      <= 1'b1;
            state_q     <= READ;
          end
        end
        READ: begin
          // k_q is the coefficient index currently on rdaddress
          if (k_q == '0) begin
            rden_q  <= 1'b0;
            state_q <= DRAIN;
          end else begin
            k_q         <= k_q - DEG_W'(1);
            rdaddress_q <= base_q + 8'(k_q) - 8'd1;
          end
        end
        DRAIN: begin
          result_q <= acc_d;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef OMEGA_EVAL_ZERO_FLAG_EN
  logic result_zero_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      result_zero_q <= 1'b0;
    end else if (state_q == DRAIN) begin
      result_zero_q <= (acc_d == 8'h00);
    end
  end

  assign result_zero = result_zero_q;
`endif

  assign rden      = rden_q;
  assign rdaddress = rdaddress_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;

endmodule

// File: tb/tb_omega_evaluator.sv
// Directed table-driven bench for omega_evaluator with a 1-cycle-latency buffer model.
module tb_omega_evaluator;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] base_addr = '0;
  logic [3:0] degree = '0;
  logic [7:0] eval_point = '0;
  logic [7:0] rdaddress;
  logic       rden;
  logic [7:0] q = '0;
  logic       busy;
  logic       done;
  logic [7:0] result;
`ifdef OMEGA_EVAL_ZERO_FLAG_EN
  logic       result_zero;
`endif

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [256];

  always #5 clock = ~clock;

  always @(posedge clock) if (rden) q <= mem[rdaddress];

  omega_evaluator dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .degree     (degree),
    .eval_point (eval_point),
    .rdaddress  (rdaddress),
    .rden       (rden),
    .q          (q),
    .busy       (busy),
    .done       (done),
    .result     (result)
`ifdef OMEGA_EVAL_ZERO_FLAG_EN
    ,
    .result_zero(result_zero)
`endif
  );

  typedef struct {
    logic [7:0]       base;
    logic [3:0]       deg;
    logic [7:0]       x;
    logic [15:0][7:0] coef;
    logic [7:0]       exp_res;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [7:0] b, input logic [3:0] d, input logic [7:0] x,
                               input logic [7:0] r, input logic [7:0] c0, input logic [7:0] c1,
                               input logic [7:0] c2, input logic [7:0] c3);
    vec_t v;
    v.base = b; v.deg = d; v.x = x; v.exp_res = r;
    v.coef = '0;
    v.coef[0] = c0; v.coef[1] = c1; v.coef[2] = c2; v.coef[3] = c3;
    return v;
  endfunction

  // Issues one request and follows it to done; extra=1 pulses start again mid-READ.
  task automatic run_op(input vec_t v, input bit extra, input string nm);
    int  cyc;
    int  nreads;
    bit  got_done;
    logic [7:0] exp_addr;
    for (int k = 0; k <= int'(v.deg); k++) mem[8'(int'(v.base) + k)] = v.coef[k];
    @(negedge clock);
    check({nm, "_idle_done"}, {31'd0, done}, 32'd0);
    check({nm, "_idle_busy"}, {31'd0, busy}, 32'd0);
    base_addr = v.base; degree = v.deg; eval_point = v.x; start = 1'b1;
    @(negedge clock);
    start = 1'b0; base_addr = 8'hAA; degree = 4'hF; eval_point = 8'h33;
    cyc = 1; nreads = 0; got_done = 1'b0;
    while (!got_done && cyc < 40) begin
      if (rden) begin
        exp_addr = 8'(int'(v.base) + int'(v.deg) - nreads);
        check({nm, "_rdaddr"}, {24'd0, rdaddress}, {24'd0, exp_addr});
        nreads++;
      end
      check({nm, "_busy"}, {31'd0, busy}, {31'd0, (cyc <= int'(v.deg) + 2)});
      if (done) begin
        got_done = 1'b1;
        check({nm, "_done_cycle"}, cyc, int'(v.deg) + 3);
        check({nm, "_result"}, {24'd0, result}, {24'd0, v.exp_res});
        check({nm, "_nreads"}, nreads, int'(v.deg) + 1);
`ifdef OMEGA_EVAL_ZERO_FLAG_EN
        check({nm, "_zero_flag"}, {31'd0, result_zero}, {31'd0, (v.exp_res == 8'h00)});
`endif
      end else begin
        start = extra && (cyc == 2);
        @(negedge clock);
        cyc++;
      end
    end
    start = 1'b0;
    check({nm, "_done_seen"}, {31'd0, got_done}, 32'd1);
  endtask

  task automatic watch_no_done(input int n, input string nm);
    int cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (done) cnt++;
    end
    check(nm, cnt, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    vecs[0] = mkv(8'h10, 4'd0, 8'h57, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00);
    vecs[1] = mkv(8'h00, 4'd2, 8'h02, 8'h0F, 8'h01, 8'h03, 8'h02, 8'h00);
    vecs[2] = mkv(8'h20, 4'd1, 8'h80, 8'h1D, 8'h00, 8'h02, 8'h00, 8'h00);
    vecs[3] = mkv(8'h20, 4'd1, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00);
    vecs[4] = mkv(8'hFE, 4'd3, 8'h02, 8'h09, 8'h05, 8'h00, 8'h01, 8'h01);
    vecs[5] = mkv(8'h30, 4'd1, 8'h03, 8'h9C, 8'h01, 8'h80, 8'h00, 8'h00);
    vecs[6] = mkv(8'h40, 4'd15, 8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00);
    for (int k = 0; k < 16; k++) vecs[6].coef[k] = 8'(k + 1);
    vecs[7] = mkv(8'h50, 4'd2, 8'h00, 8'h5A, 8'h5A, 8'h11, 8'h22, 8'h00);

    repeat (2) @(negedge clock);
    check("rst_rden", {31'd0, rden}, 32'd0);
    check("rst_rdaddr", {24'd0, rdaddress}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", {24'd0, result}, 32'd0);
    reset = 1'b0;

    // Each op starts in the IDLE cycle right after the previous DONE
    for (int i = 0; i < 8; i++) run_op(vecs[i], 1'b0, $sformatf("vec%0d", i));

    run_op(vecs[1], 1'b1, "busy_ign");
    watch_no_done(20, "busy_ign_single_done");

    // Reset during cycle 2 of a D=5 run
    for (int k = 0; k < 6; k++) mem[8'(8'h60 + k)] = 8'(8'h11 * (k + 1));
    @(negedge clock);
    base_addr = 8'h60; degree = 4'd5; eval_point = 8'h02; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst_rden", {31'd0, rden}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_result", {24'd0, result}, 32'd0);
    check("midrst_rdaddr", {24'd0, rdaddress}, 32'd0);
    watch_no_done(15, "midrst_no_done");

    // Reset wins over a simultaneous start
    reset = 1'b1; start = 1'b1; base_addr = 8'h00; degree = 4'd2; eval_point = 8'h02;
    @(negedge clock);
    reset = 1'b0; start = 1'b0;
    check("rstprio_busy", {31'd0, busy}, 32'd0);
    check("rstprio_rden", {31'd0, rden}, 32'd0);
    @(negedge clock);
    check("rstprio_rden2", {31'd0, rden}, 32'd0);

    run_op(vecs[5], 1'b0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/omega_evaluator.md
Name: omega_evaluator

Overview:
Downstream consumer of omega_buffer_1 in the Reed-Solomon decoder: evaluates the error-evaluator polynomial omega(x) at one GF(2^8) point per request.
- Reads coefficients from the buffer's read port, highest degree first.
- Computes the value by Horner's rule: acc = acc*x + c_k.
- Result feeds the Forney error-magnitude stage.

Parameters:
PRIM_POLY, 9'h11D, GF(2^8) field generator polynomial.
DEG_W, 4, width of the degree input; maximum omega degree is 2^DEG_W-1 (2T-1 for T=8).

Ports:
clock  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request pulse; sampled only in IDLE.
base_addr  input  8  buffer address of coefficient c0; c_k sits at base_addr+k mod 256.
degree  input  DEG_W  degree D of omega.
eval_point  input  8  evaluation point x (alpha^-i from Chien search).
rdaddress  output  8  to omega_buffer_1 rdaddress.
rden  output  1  to omega_buffer_1 rden.
q  input  8  from omega_buffer_1 q; valid exactly 1 cycle after rden/rdaddress.
busy  output  1  high from the cycle after start is accepted until done.
done  output  1  one-cycle pulse; result valid.
result  output  8  omega(x); held until the next accepted start.

Behaviour:
- Reset: state IDLE, rden=0, rdaddress=0, busy=0, done=0, result=0, internal acc=0, counter=0.
- IDLE:
  - On start=1, latch base_addr, degree and eval_point; set k=D, acc=0.
  - Go to READ.
- READ (D+1 cycles):
  - Drive rden=1 and rdaddress=base+k (8-bit wrap).
  - Decrement k. On k=0 go to DRAIN.
  - Every cycle in which the previous cycle had rden=1: acc <= gf_mul(acc, x) XOR q.
- DRAIN (1 cycle):
  - rden=0; final accumulate of c0.
  - Go to DONE.
- DONE (1 cycle):
  - result <= acc; done=1, busy=0.
  - Go to IDLE.
- Latency: start accepted in cycle 0; reads in cycles 1..D+1; done at cycle D+3. Total D+3 cycles.
- Back-to-back: a new start is accepted in the IDLE cycle immediately after DONE.
- start while busy is ignored; no queuing.
- Inputs are latched on accept; later changes to them have no effect on an operation in progress.
- D=0: exactly one read; done at cycle 3; result=c0.
- Address wrap: base+k computed mod 256. Example: base=0xFE, D=3 reads 0x01,0x00,0xFF,0xFE.
- GF multiply: polynomial product reduced mod PRIM_POLY; purely combinational, one per cycle.
- eval_point=0 is legal; result=c0.
- Reset mid-operation: next cycle in IDLE with all outputs at reset values. A pending buffer read is discarded; no done pulse.
- reset has priority over start in the same cycle.

Optional Feature:
OMEGA_EVAL_ZERO_FLAG_EN:
- Defined: adds output result_zero (1 bit). Registered with result in DONE; equals (acc==0). Reset value 0; held with result.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package rs_pkg: GF_W=8, PRIM_POLY default, state enum {IDLE, READ, DRAIN, DONE}, gf_mul function prototype constant table (none required).
- One sub-module: gf_mult8, a combinational GF(2^8) multiplier parameterised on PRIM_POLY, reusable by the Chien and Forney stages.

Test Plan:
- Degree 0: c0=0x01 at base 0x10, x=0x57, start -> 1 read at 0x10; done at cycle 3; result=0x01.
- Horner check: c2=0x02, c1=0x03, c0=0x01 at base 0x00, x=0x02 -> reads 0x02,0x01,0x00 in cycles 1-3; done at cycle 5; result=0x0F.
- Field reduction: c1=0x02, c0=0x00, x=0x80 -> result=0x1D. Also x=0 -> result=c0=0x00.
- Wrap-around: base=0xFE, D=3 -> rdaddress sequence 0x01,0x00,0xFF,0xFE; result matches software model.
- Busy/back-to-back: extra start during READ ignored (single done). Second start in the IDLE cycle after DONE accepted; results correct.
- Reset mid-op: assert reset in cycle 2 of a D=5 run -> next cycle rden=0, busy=0, done=0, result=0; no done pulse. A fresh start then completes normally.
